// File: rtl/c16_matrix_encoder.sv
// c16_matrix_encoder
//   Scans a Commodore 16 key matrix one key per cycle and converts every
//   state change into a PS/2 set-2 byte sequence ([E0] [F0] code), with GAP
//   idle cycles after each byte.
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   keys_n      matrix state, 0 = pressed, bit index = col*8 + row
//   scancode    last delivered byte (held between strobes)
//   receiveflag one-cycle strobe, scancode valid
//   busy        high while an event is being emitted
module c16_matrix_encoder #(
  parameter int unsigned GAP = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] keys_n,
  output logic [7:0]  scancode,
  output logic        receiveflag,
  output logic        busy
);

  typedef enum logic [2:0] {SCAN, EMIT_E0, EMIT_F0, EMIT_CODE, GAP_WAIT} state_e;

  localparam logic [7:0] GAP_M1 = (GAP == 0) ? 8'd0 : 8'(GAP - 1);

  state_e      state_q, state_d;
  state_e      last_q, last_d;
  state_e      from_st, follow;
  logic [5:0]  ptr_q, ptr_d;
  logic [63:0] stored_q, stored_d;
  logic [5:0]  idx_q, idx_d;
  logic        brk_q, brk_d;
  logic [7:0]  gap_q, gap_d;
  logic [7:0]  scancode_q, scancode_d;
  logic        rf_q, rf_d;
  logic        finish;
  logic [8:0]  ptr_lut, idx_lut;

  // {extended, code}
  function automatic logic [8:0] code_lut(input logic [5:0] i);
    logic [8:0] r;
    r = '0;
    case (i)
      6'd0:  r = 9'h066; 6'd1:  r = 9'h026; 6'd2:  r = 9'h02E; 6'd3:  r = 9'h03D;
      6'd4:  r = 9'h046; 6'd5:  r = 9'h172; 6'd6:  r = 9'h16B; 6'd7:  r = 9'h016;
      6'd8:  r = 9'h05A; 6'd9:  r = 9'h01D; 6'd10: r = 9'h02D; 6'd11: r = 9'h035;
      6'd12: r = 9'h043; 6'd13: r = 9'h04D; 6'd14: r = 9'h05B; 6'd15: r = 9'h16C;
      6'd16: r = 9'h12F; 6'd17: r = 9'h01C; 6'd18: r = 9'h023; 6'd19: r = 9'h034;
      6'd20: r = 9'h03B; 6'd21: r = 9'h04B; 6'd22: r = 9'h052; 6'd23: r = 9'h014;
      6'd24: r = 9'h00C; 6'd25: r = 9'h025; 6'd26: r = 9'h036; 6'd27: r = 9'h03E;
      6'd28: r = 9'h045; 6'd29: r = 9'h175; 6'd30: r = 9'h174; 6'd31: r = 9'h01E;
      6'd32: r = 9'h005; 6'd33: r = 9'h01A; 6'd34: r = 9'h021; 6'd35: r = 9'h032;
      6'd36: r = 9'h03A; 6'd37: r = 9'h049; 6'd38: r = 9'h076; 6'd39: r = 9'h029;
      6'd40: r = 9'h006; 6'd41: r = 9'h01B; 6'd42: r = 9'h02B; 6'd43: r = 9'h033;
      6'd44: r = 9'h042; 6'd45: r = 9'h04C; 6'd46: r = 9'h05D; 6'd47: r = 9'h11F;
      6'd48: r = 9'h004; 6'd49: r = 9'h024; 6'd50: r = 9'h02C; 6'd51: r = 9'h03C;
      6'd52: r = 9'h044; 6'd53: r = 9'h04E; 6'd54: r = 9'h055; 6'd55: r = 9'h015;
      6'd56: r = 9'h054; 6'd57: r = 9'h012; 6'd58: r = 9'h022; 6'd59: r = 9'h02A;
      6'd60: r = 9'h031; 6'd61: r = 9'h041; 6'd62: r = 9'h04A; 6'd63: r = 9'h00D;
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    ptr_d    = ptr_q;
    stored_d = stored_q;
    idx_d    = idx_q;
    brk_d    = brk_q;
    gap_d    = gap_q;
    finish   = 1'b0;
    ptr_lut  = code_lut(ptr_q);

    // Byte that follows the one just emitted (or the one before the gap).
    from_st = (state_q == GAP_WAIT) ? last_q : state_q;
    case (from_st)
      EMIT_E0: follow = brk_q ? EMIT_F0 : EMIT_CODE;
      EMIT_F0: follow = EMIT_CODE;
      default: follow = SCAN;
    endcase

    case (state_q)
      SCAN: begin
        if (keys_n[ptr_q] != stored_q[ptr_q]) begin
          idx_d = ptr_q;
          brk_d = keys_n[ptr_q];
          if (ptr_lut[8])       state_d = EMIT_E0;
          else if (keys_n[ptr_q]) state_d = EMIT_F0;
          else                  state_d = EMIT_CODE;
        end else begin
          ptr_d = ptr_q + 6'd1;
        end
      end
      EMIT_E0, EMIT_F0, EMIT_CODE: begin
        last_d = state_q;
        if (GAP == 0) begin
          if (follow == SCAN) finish = 1'b1;
          else                state_d = follow;
        end else begin
          state_d = GAP_WAIT;
          gap_d   = GAP_M1;
        end
      end
      GAP_WAIT: begin
        if (gap_q != '0)          gap_d = gap_q - 8'd1;
        else if (follow == SCAN)  finish = 1'b1;
        else                      state_d = follow;
      end
      default: state_d = SCAN;
    endcase

    if (finish) begin
      stored_d[idx_q] = brk_q;
      ptr_d           = idx_q + 6'd1;
      state_d         = SCAN;
    end
  end

  // Outputs are registered on entry to an EMIT state so the strobe is
  // visible during the cycle the FSM sits in that state.
  always_comb begin
    idx_lut    = code_lut(idx_d);
    scancode_d = scancode_q;
    rf_d       = 1'b0;
    case (state_d)
      EMIT_E0:   begin scancode_d = 8'hE0;         rf_d = 1'b1; end
      EMIT_F0:   begin scancode_d = 8'hF0;         rf_d = 1'b1; end
      EMIT_CODE: begin scancode_d = idx_lut[7:0];  rf_d = 1'b1; end
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SCAN;
      last_q     <= SCAN;
      ptr_q      <= '0;
      stored_q   <= '1;
      idx_q      <= '0;
      brk_q      <= 1'b0;
      gap_q      <= '0;
      scancode_q <= '0;
      rf_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      ptr_q      <= ptr_d;
      stored_q   <= stored_d;
      idx_q      <= idx_d;
      brk_q      <= brk_d;
      gap_q      <= gap_d;
      scancode_q <= scancode_d;
      rf_q       <= rf_d;
    end
  end

  assign scancode    = scancode_q;
  assign receiveflag = rf_q;
  assign busy        = (state_q != SCAN);

endmodule

// File: tb/tb_c16_matrix_encoder.sv
// Testbench for c16_matrix_encoder: one instance with GAP=15, one with GAP=0.
module tb_c16_matrix_encoder;

  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic [63:0] keys0, keys1;
  logic [7:0]  sc0, sc1;
  logic        rf0, rf1, busy0, busy1;

  c16_matrix_encoder #(.GAP(15)) dut (
    .clk(clk), .reset(rst0), .keys_n(keys0),
    .scancode(sc0), .receiveflag(rf0), .busy(busy0));

  c16_matrix_encoder #(.GAP(0)) dut0 (
    .clk(clk), .reset(rst1), .keys_n(keys1),
    .scancode(sc1), .receiveflag(rf1), .busy(busy1));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int obs_b[$];
  int obs_t[$];
  bit bh [2][32768];

  // Spec code table, column by column, 'hE.. marks an extended key.
  int unsigned tbl [64] = '{
    'h066, 'h026, 'h02E, 'h03D, 'h046, 'hE72, 'hE6B, 'h016,
    'h05A, 'h01D, 'h02D, 'h035, 'h043, 'h04D, 'h05B, 'hE6C,
    'hE2F, 'h01C, 'h023, 'h034, 'h03B, 'h04B, 'h052, 'h014,
    'h00C, 'h025, 'h036, 'h03E, 'h045, 'hE75, 'hE74, 'h01E,
    'h005, 'h01A, 'h021, 'h032, 'h03A, 'h049, 'h076, 'h029,
    'h006, 'h01B, 'h02B, 'h033, 'h042, 'h04C, 'h05D, 'hE1F,
    'h004, 'h024, 'h02C, 'h03C, 'h044, 'h04E, 'h055, 'h015,
    'h054, 'h012, 'h022, 'h02A, 'h031, 'h041, 'h04A, 'h00D};

  typedef struct {
    int idx;
    bit press;
    int n;
    int b [3];
  } vec_t;
  vec_t vt [12];

  int evb [4][3];
  int evn [4];
  int nev;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bh[0][cyc % 32768] = busy0;
    bh[1][cyc % 32768] = busy1;
    if (rf0) begin obs_b.push_back(int'(sc0)); obs_t.push_back(cyc); end
    if (rf1) begin obs_b.push_back(int'(sc1)); obs_t.push_back(cyc); end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_key(input int d, input int idx, input bit v);
    if (d == 0) keys0[idx] = v;
    else        keys1[idx] = v;
  endtask

  task automatic wait_idle(input int d);
    int quiet = 0;
    int n = 0;
    while (quiet < 70 && n < 4000) begin
      @(negedge clk);
      n++;
      if ((d == 0) ? busy0 : busy1) quiet = 0;
      else quiet++;
    end
    chk("idle_reached", int'(quiet >= 70), 1);
  endtask

  task automatic run_vectors(input int d, input int gap);
    int lows;
    for (int v = 0; v < 12; v++) begin
      tick();
      obs_b.delete();
      obs_t.delete();
      set_key(d, vt[v].idx, !vt[v].press);
      wait_idle(d);
      chk($sformatf("vec%0d_d%0d_count", v, d), obs_b.size(), vt[v].n);
      if (obs_b.size() == vt[v].n) begin
        for (int i = 0; i < vt[v].n; i++) begin
          chk($sformatf("vec%0d_d%0d_byte%0d", v, d, i), obs_b[i], vt[v].b[i]);
          if (i > 0)
            chk($sformatf("vec%0d_d%0d_spacing%0d", v, d, i), obs_t[i] - obs_t[i-1], gap + 1);
        end
        lows = 0;
        for (int t = obs_t[0]; t <= obs_t[vt[v].n - 1]; t++)
          if (!bh[d][t % 32768]) lows++;
        chk($sformatf("vec%0d_d%0d_busy_low_cycles", v, d), lows, 0);
      end
    end
  endtask

  task automatic random_trial(input int d, input int trial);
    logic [63:0] mask, after;
    int k, idx, cnt, nb;
    bit any, eq;
    int flat[$];
    mask = '0;
    k = int'($urandom_range(1, 4));
    cnt = 0;
    while (cnt < k) begin
      idx = int'($urandom_range(0, 63));
      if (!mask[idx]) begin mask[idx] = 1'b1; cnt++; end
    end
    tick();
    obs_b.delete();
    obs_t.delete();
    if (d == 0) begin keys0 = keys0 ^ mask; after = keys0; end
    else        begin keys1 = keys1 ^ mask; after = keys1; end
    nev = 0;
    nb = 0;
    for (int i = 0; i < 64; i++) begin
      if (mask[i]) begin
        evn[nev] = 0;
        if ((tbl[i] >> 8) == 'hE) begin evb[nev][evn[nev]] = 'hE0; evn[nev]++; end
        if (after[i])             begin evb[nev][evn[nev]] = 'hF0; evn[nev]++; end
        evb[nev][evn[nev]] = int'(tbl[i] & 'hFF);
        evn[nev]++;
        nb += evn[nev];
        nev++;
      end
    end
    wait_idle(d);
    chk($sformatf("rand%0d_d%0d_count", trial, d), obs_b.size(), nb);
    // Events must appear in ascending index order starting at some pointer.
    any = 1'b0;
    for (int r = 0; r < nev; r++) begin
      flat.delete();
      for (int e = 0; e < nev; e++)
        for (int j = 0; j < evn[(e + r) % nev]; j++)
          flat.push_back(evb[(e + r) % nev][j]);
      if (flat.size() == obs_b.size()) begin
        eq = 1'b1;
        for (int i = 0; i < flat.size(); i++)
          if (flat[i] != obs_b[i]) eq = 1'b0;
        if (eq) any = 1'b1;
      end
    end
    chk($sformatf("rand%0d_d%0d_sequence", trial, d), int'(any), 1);
  endtask

  initial begin
    int rfh, bsh, c_rel;

    vt[0]  = '{17, 1'b1, 1, '{'h1C, 0, 0}};
    vt[1]  = '{17, 1'b0, 2, '{'hF0, 'h1C, 0}};
    vt[2]  = '{29, 1'b1, 2, '{'hE0, 'h75, 0}};
    vt[3]  = '{29, 1'b0, 3, '{'hE0, 'hF0, 'h75}};
    vt[4]  = '{0,  1'b1, 1, '{'h66, 0, 0}};
    vt[5]  = '{0,  1'b0, 2, '{'hF0, 'h66, 0}};
    vt[6]  = '{47, 1'b1, 2, '{'hE0, 'h1F, 0}};
    vt[7]  = '{47, 1'b0, 3, '{'hE0, 'hF0, 'h1F}};
    vt[8]  = '{63, 1'b1, 1, '{'h0D, 0, 0}};
    vt[9]  = '{63, 1'b0, 2, '{'hF0, 'h0D, 0}};
    vt[10] = '{16, 1'b1, 2, '{'hE0, 'h2F, 0}};
    vt[11] = '{16, 1'b0, 3, '{'hE0, 'hF0, 'h2F}};

    rst0 = 1'b1;
    rst1 = 1'b1;
    keys0 = '1;
    keys1 = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_scancode_d0", int'(sc0), 0);
    chk("reset_rflag_d0", int'(rf0), 0);
    chk("reset_busy_d0", int'(busy0), 0);
    chk("reset_scancode_d1", int'(sc1), 0);
    chk("reset_busy_d1", int'(busy1), 0);
    tick();
    rst0 = 1'b0;
    rst1 = 1'b0;

    // All keys released: nothing to report.
    rfh = 0;
    bsh = 0;
    repeat (300) begin
      @(negedge clk);
      if (rf0 || rf1) rfh++;
      if (busy0 || busy1) bsh++;
    end
    chk("idle_rflag_cycles", rfh, 0);
    chk("idle_busy_cycles", bsh, 0);

    run_vectors(0, 15);
    run_vectors(1, 0);

    // Two keys changing together right after reset (ptr=0): 16 before 12.
    tick();
    rst0 = 1'b1;
    keys0[7]  = 1'b0;
    keys0[57] = 1'b0;
    tick();
    tick();
    obs_b.delete();
    obs_t.delete();
    rst0 = 1'b0;
    wait_idle(0);
    chk("simul_count", obs_b.size(), 2);
    if (obs_b.size() == 2) begin
      chk("simul_first", obs_b[0], 'h16);
      chk("simul_second", obs_b[1], 'h12);
      chk("simul_first_done", int'(obs_t[1] - obs_t[0] >= 16), 1);
    end
    tick();
    obs_b.delete();
    obs_t.delete();
    keys0[7]  = 1'b1;
    keys0[57] = 1'b1;
    wait_idle(0);
    chk("simul_release_count", obs_b.size(), 4);

    // Reset in the middle of a release event aborts it.
    tick();
    keys0[29] = 1'b0;
    wait_idle(0);
    tick();
    obs_b.delete();
    obs_t.delete();
    keys0[29] = 1'b1;
    for (int n = 0; n < 200 && obs_b.size() == 0; n++) @(negedge clk);
    chk("abort_first_strobe_seen", obs_b.size(), 1);
    tick();
    rst0 = 1'b1;
    tick();
    @(negedge clk);
    chk("abort_reset_rflag", int'(rf0), 0);
    chk("abort_reset_scancode", int'(sc0), 0);
    chk("abort_reset_busy", int'(busy0), 0);
    tick();
    rst0 = 1'b0;
    repeat (200) @(negedge clk);
    chk("abort_strobe_count", obs_b.size(), 1);
    if (obs_b.size() >= 1) chk("abort_only_e0", obs_b[0], 'hE0);

    // Key held through reset: make code on the first cycle after reset.
    tick();
    rst0 = 1'b1;
    keys0[0] = 1'b0;
    tick();
    tick();
    obs_b.delete();
    obs_t.delete();
    rst0 = 1'b0;
    c_rel = cyc;
    wait_idle(0);
    chk("held_count", obs_b.size(), 1);
    if (obs_b.size() == 1) begin
      chk("held_code", obs_b[0], 'h66);
      chk("held_latency", obs_t[0], c_rel + 1);
    end
    tick();
    keys0[0] = 1'b1;
    wait_idle(0);

    for (int t = 0; t < 12; t++) random_trial(0, t);
    for (int t = 0; t < 12; t++) random_trial(1, t);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
